// File: rtl/mux8_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// mux8_rr_scheduler_if
//
// Purpose:
//   Groups the request, mux-control and downstream handshake signals of
//   mux8_rr_scheduler. Signal names keep their _i/_o suffixes as seen from
//   the scheduler, so the RTL and the surrounding hub read the same way.
//
// Parameters:
//   SEL_W        width of sel_o (mux select); only the low 3 bits carry data.
//
// Signals:
//   enable_i      1 = new grants allowed; 0 = finish in-flight transfer only
//   req_i[7:0]    per-channel request level, held until acknowledged
//   chan_mask_i   per-channel eligibility, looked at only while idle
//   sel_o         mux select, binary channel index (upper bits are 0)
//   en_sel_o      mux load enable, one-cycle pulse
//   out_valid_o   mux output holds a valid byte for downstream
//   out_ready_i   downstream accepts the byte when out_valid_o & out_ready_i
//   chan_o[2:0]   index of the channel being offered
//   req_ack_o     one-hot, one-cycle acknowledge to the served channel
//   busy_o        scheduler is not idle
//   timeout_err_o one-cycle watchdog pulse (only with MUX8_SCHED_TIMEOUT_EN)
//
// Modports:
//   master  the scheduler itself
//   slave   the channel buffers / downstream side
//
// Build option:
//   MUX8_SCHED_TIMEOUT_EN adds timeout_err_o.
// -----------------------------------------------------------------------------
interface mux8_rr_scheduler_if #(
  parameter int SEL_W = 8
);

  logic             enable_i;
  logic [7:0]       req_i;
  logic [7:0]       chan_mask_i;
  logic [SEL_W-1:0] sel_o;
  logic             en_sel_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0]       chan_o;
  logic [7:0]       req_ack_o;
  logic             busy_o;
`ifdef MUX8_SCHED_TIMEOUT_EN
  logic             timeout_err_o;
`endif

  modport master (
    input  enable_i,
    input  req_i,
    input  chan_mask_i,
    input  out_ready_i,
    output sel_o,
    output en_sel_o,
    output out_valid_o,
    output chan_o,
    output req_ack_o,
    output busy_o
`ifdef MUX8_SCHED_TIMEOUT_EN
    , output timeout_err_o
`endif
  );

  modport slave (
    output enable_i,
    output req_i,
    output chan_mask_i,
    output out_ready_i,
    input  sel_o,
    input  en_sel_o,
    input  out_valid_o,
    input  chan_o,
    input  req_ack_o,
    input  busy_o
`ifdef MUX8_SCHED_TIMEOUT_EN
    , input timeout_err_o
`endif
  );

endinterface : mux8_rr_scheduler_if

// File: rtl/mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux8_rr_scheduler
//
// Purpose:
//   Round-robin scheduler sharing one 8-input registered byte mux between
//   eight receive buffers. One transfer is in flight at a time:
//     IDLE    -> pick a winner among req_i & chan_mask_i, latch sel_o
//     SELECT  -> pulse en_sel_o so the mux loads at the end of this cycle
//     OFFER   -> out_valid_o high until downstream takes the byte
//     RELEASE -> one-hot req_ack_o to the served channel, advance pointer
//   Minimum 4 cycles per transfer. All outputs come straight from registers.
//
// Parameters:
//   SEL_W          width of sel_o, must match the mux select width (>= 3)
//   PTR_RST        round-robin pointer value after reset (0..7)
//   TIMEOUT_CYCLES OFFER watchdog limit (only with MUX8_SCHED_TIMEOUT_EN)
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-low reset
//   bus   mux8_rr_scheduler_if.master (request, mux control, handshake)
//
// Build option:
//   MUX8_SCHED_TIMEOUT_EN  when defined, an OFFER that sees no out_ready_i for
//                          TIMEOUT_CYCLES consecutive cycles is dropped: no
//                          ack, timeout_err_o pulses, and the stalled channel
//                          loses priority. When undefined OFFER waits forever.
// -----------------------------------------------------------------------------
module mux8_rr_scheduler #(
  parameter int SEL_W          = 8,
  parameter int PTR_RST        = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 rst,
  mux8_rr_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_OFFER   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [2:0] r_ptr;        // highest-priority channel for the next grant
  logic [2:0] r_sel;        // channel being served; moves only on IDLE->SELECT
  logic       r_en_sel;
  logic       r_out_valid;
  logic [7:0] r_req_ack;
  logic       r_busy;

`ifdef MUX8_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;   // consecutive OFFER cycles without out_ready_i
  logic            r_timeout_err;
`else
  // The watchdog limit has no meaning in this build.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Round-robin winner selection
  // ---------------------------------------------------------------------------
  // Scan ptr, ptr+1, ..., ptr+7 (mod 8) and return the first eligible channel.
  // The return value only matters when at least one bit of elig is set.
  function automatic logic [2:0] rr_pick(input logic [7:0] elig,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    // NOTE: every variable gets a value before any conditional assignment, so
    // no path leaves one holding a stale value (in always_comb that is a latch).
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && elig[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic [7:0] w_eligible;
  logic       w_any_eligible;
  logic [2:0] w_winner;

  assign w_eligible     = bus.req_i & bus.chan_mask_i;
  assign w_any_eligible = |w_eligible;
  assign w_winner       = rr_pick(w_eligible, r_ptr);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset abandons any transfer in flight; no acknowledge is produced.
      r_state     <= ST_IDLE;
      r_ptr       <= 3'(PTR_RST);
      r_sel       <= 3'd0;
      r_en_sel    <= 1'b0;
      r_out_valid <= 1'b0;
      r_req_ack   <= 8'h00;
      r_busy      <= 1'b0;
`ifdef MUX8_SCHED_TIMEOUT_EN
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; they fall back to 0 unless re-armed below.
      r_en_sel  <= 1'b0;
      r_req_ack <= 8'h00;
`ifdef MUX8_SCHED_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif

      unique case (r_state)
        ST_IDLE: begin
          // enable_i and chan_mask_i only gate the start of a transfer.
          if (bus.enable_i && w_any_eligible) begin
            r_state  <= ST_SELECT;
            r_sel    <= w_winner;
            r_en_sel <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        ST_SELECT: begin
          // The mux loads on the edge that ends this cycle, so its output is
          // valid from the first OFFER cycle on.
          r_state     <= ST_OFFER;
          r_out_valid <= 1'b1;
`ifdef MUX8_SCHED_TIMEOUT_EN
          r_wd_cnt    <= '0;
`endif
        end

        ST_OFFER: begin
          if (bus.out_ready_i) begin
            // Byte accepted this cycle; acknowledge the served channel next.
            r_state     <= ST_RELEASE;
            r_out_valid <= 1'b0;
            r_req_ack   <= 8'(1) << r_sel;
            r_ptr       <= r_sel + 3'd1;
          end
`ifdef MUX8_SCHED_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            // Downstream stalled too long: drop the byte without an ack and
            // move the pointer past the stalled channel.
            r_state       <= ST_IDLE;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_ptr         <= r_sel + 3'd1;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
`endif
        end

        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.sel_o       = SEL_W'(r_sel);   // upper SEL_W-3 bits are 0
  assign bus.chan_o      = r_sel;
  assign bus.en_sel_o    = r_en_sel;
  assign bus.out_valid_o = r_out_valid;
  assign bus.req_ack_o   = r_req_ack;
  assign bus.busy_o      = r_busy;
`ifdef MUX8_SCHED_TIMEOUT_EN
  assign bus.timeout_err_o = r_timeout_err;
`endif

endmodule : mux8_rr_scheduler

// File: tb/tb_mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_scheduler
//
// Directed testbench for mux8_rr_scheduler. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at the same point, so every
// sample shows the registers loaded by the edge just passed.
// Build option MUX8_SCHED_TIMEOUT_EN adds the watchdog scenario
// (TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux8_rr_scheduler;

`ifdef MUX8_SCHED_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [21:0] e;

  mux8_rr_scheduler_if #(.SEL_W(8)) bus ();

  mux8_rr_scheduler #(
    .SEL_W         (8),
    .PTR_RST       (0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, en_sel, out_valid, sel[7:0], chan[2:0], req_ack[7:0]}
  function automatic logic [21:0] snap();
    return {bus.busy_o, bus.en_sel_o, bus.out_valid_o, bus.sel_o,
            bus.chan_o, bus.req_ack_o};
  endfunction

  function automatic logic [21:0] mk(input logic busy, input logic en_sel,
                                     input logic valid, input logic [2:0] ch,
                                     input logic [7:0] ack);
    return {busy, en_sel, valid, {5'b0, ch}, ch, ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Reset with every input active: outputs must all be 0.
  task automatic test_reset();
    rst = 1'b0;
    bus.enable_i = 1'b1; bus.req_i = 8'hFF; bus.chan_mask_i = 8'hFF;
    bus.out_ready_i = 1'b1;
    tick(); tick();
    e = mk(0, 0, 0, 3'd0, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL reset_outputs: got %h want %h", snap(), e); else n_pass++;
`ifdef MUX8_SCHED_TIMEOUT_EN
    n_total++;
    if (bus.timeout_err_o !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err_o); else n_pass++;
`endif
    bus.req_i = 8'h00;
    rst = 1'b1;
    tick();
    n_total++;
    if (snap() !== e) $display("FAIL reset_idle: got %h want %h", snap(), e); else n_pass++;
  endtask

  // Single request on ch3 with ready held high: 4-cycle transfer.
  task automatic test_single();
    bus.enable_i = 1'b1; bus.chan_mask_i = 8'hFF; bus.out_ready_i = 1'b1;
    bus.req_i = 8'h08;
    tick(); e = mk(1, 1, 0, 3'd3, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL single_select: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(1, 0, 1, 3'd3, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL single_offer: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(1, 0, 0, 3'd3, 8'h08);
    n_total++;
    if (snap() !== e) $display("FAIL single_release: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(0, 0, 0, 3'd3, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL single_idle: got %h want %h", snap(), e); else n_pass++;
    bus.req_i = 8'h00;
    tick();
    n_total++;
    if (snap() !== e) $display("FAIL single_stay_idle: got %h want %h", snap(), e); else n_pass++;
  endtask

  // All eight channels requesting from ptr=0: served 0..7, 4 cycles each.
  task automatic test_round_robin();
    logic [7:0] ack;
    do_reset();
    bus.out_ready_i = 1'b1;
    bus.req_i = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      ack = 8'h00;
      ack[k] = 1'b1;
      tick(); e = mk(1, 1, 0, 3'(k), 8'h00);
      n_total++;
      if (snap() !== e) $display("FAIL rr_select ch%0d: got %h want %h", k, snap(), e); else n_pass++;
      tick(); e = mk(1, 0, 1, 3'(k), 8'h00);
      n_total++;
      if (snap() !== e) $display("FAIL rr_offer ch%0d: got %h want %h", k, snap(), e); else n_pass++;
      tick(); e = mk(1, 0, 0, 3'(k), ack);
      n_total++;
      if (snap() !== e) $display("FAIL rr_release ch%0d: got %h want %h", k, snap(), e); else n_pass++;
      tick(); e = mk(0, 0, 0, 3'(k), 8'h00);
      n_total++;
      if (snap() !== e) $display("FAIL rr_idle ch%0d: got %h want %h", k, snap(), e); else n_pass++;
      bus.req_i[k] = 1'b0;
    end
  endtask

  // ch5 stalled 6 OFFER cycles; enable/mask changes mid-transfer are ignored.
  task automatic test_backpressure();
    bus.req_i = 8'h20;
    bus.out_ready_i = 1'b0;
    tick(); e = mk(1, 1, 0, 3'd5, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL bp_select: got %h want %h", snap(), e); else n_pass++;
    bus.enable_i = 1'b0;
    bus.chan_mask_i = 8'h00;
    for (int i = 0; i < 7; i++) begin
      tick(); e = mk(1, 0, 1, 3'd5, 8'h00);
      n_total++;
      if (snap() !== e) $display("FAIL bp_offer cycle%0d: got %h want %h", i, snap(), e); else n_pass++;
      if (i == 6) bus.out_ready_i = 1'b1;
    end
    tick(); e = mk(1, 0, 0, 3'd5, 8'h20);
    n_total++;
    if (snap() !== e) $display("FAIL bp_release: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(0, 0, 0, 3'd5, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL bp_idle: got %h want %h", snap(), e); else n_pass++;
    bus.req_i = 8'h00;
    bus.enable_i = 1'b1;
    bus.chan_mask_i = 8'hFF;
  endtask

  // Masked-off requests wait; enable_i=0 blocks grants; unmask grants ch4.
  task automatic test_mask_enable();
    do_reset();
    bus.out_ready_i = 1'b1;
    bus.chan_mask_i = 8'h0F;
    bus.req_i = 8'hF0;
    e = mk(0, 0, 0, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (snap() !== e) $display("FAIL mask_no_grant cycle%0d: got %h want %h", i, snap(), e); else n_pass++;
    end
    bus.chan_mask_i = 8'hFF;
    bus.enable_i = 1'b0;
    tick();
    n_total++;
    if (snap() !== e) $display("FAIL enable_low_no_grant: got %h want %h", snap(), e); else n_pass++;
    bus.enable_i = 1'b1;
    tick(); e = mk(1, 1, 0, 3'd4, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL mask_select_ch4: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(1, 0, 1, 3'd4, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL mask_offer: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(1, 0, 0, 3'd4, 8'h10);
    n_total++;
    if (snap() !== e) $display("FAIL mask_release: got %h want %h", snap(), e); else n_pass++;
    tick();
    bus.req_i = 8'h00;
  endtask

  // Reset during OFFER (ptr=5): everything clears, no ack, ptr back to 0,
  // so the next grant between ch0 and ch6 goes to ch0.
  task automatic test_reset_in_offer();
    bus.out_ready_i = 1'b0;
    bus.req_i = 8'h40;
    tick(); e = mk(1, 1, 0, 3'd6, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL rst_pre_select: got %h want %h", snap(), e); else n_pass++;
    tick(); e = mk(1, 0, 1, 3'd6, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL rst_pre_offer: got %h want %h", snap(), e); else n_pass++;
    rst = 1'b0;
    tick(); e = mk(0, 0, 0, 3'd0, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL rst_in_offer: got %h want %h", snap(), e); else n_pass++;
    rst = 1'b1;
    bus.req_i = 8'h41;
    bus.out_ready_i = 1'b1;
    tick(); e = mk(1, 1, 0, 3'd0, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL rst_ptr_restored: got %h want %h", snap(), e); else n_pass++;
    tick(); tick(); e = mk(1, 0, 0, 3'd0, 8'h01);
    n_total++;
    if (snap() !== e) $display("FAIL rst_next_release: got %h want %h", snap(), e); else n_pass++;
    tick();
    bus.req_i = 8'h00;
  endtask

`ifdef MUX8_SCHED_TIMEOUT_EN
  // ch1 and ch2 request, ready stays low: 4 OFFER cycles, timeout pulse,
  // no ack, then ch2 is granted ahead of ch1.
  task automatic test_timeout();
    do_reset();
    bus.out_ready_i = 1'b0;
    bus.req_i = 8'h06;
    tick(); e = mk(1, 1, 0, 3'd1, 8'h00);
    n_total++;
    if (snap() !== e) $display("FAIL to_select: got %h want %h", snap(), e); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(); e = mk(1, 0, 1, 3'd1, 8'h00);
      n_total++;
      if (snap() !== e || bus.timeout_err_o !== 1'b0)
        $display("FAIL to_offer cycle%0d: got %h/%b want %h/0", i, snap(), bus.timeout_err_o, e);
      else n_pass++;
    end
    tick(); e = mk(0, 0, 0, 3'd1, 8'h00);
    n_total++;
    if (snap() !== e || bus.timeout_err_o !== 1'b1)
      $display("FAIL to_pulse: got %h/%b want %h/1", snap(), bus.timeout_err_o, e);
    else n_pass++;
    tick(); e = mk(1, 1, 0, 3'd2, 8'h00);
    n_total++;
    if (snap() !== e || bus.timeout_err_o !== 1'b0)
      $display("FAIL to_next_grant: got %h/%b want %h/0", snap(), bus.timeout_err_o, e);
    else n_pass++;
    bus.out_ready_i = 1'b1;
    tick(); tick(); e = mk(1, 0, 0, 3'd2, 8'h04);
    n_total++;
    if (snap() !== e) $display("FAIL to_next_release: got %h want %h", snap(), e); else n_pass++;
    tick();
    bus.req_i = 8'h00;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b0;
    bus.enable_i = 1'b0;
    bus.req_i = 8'h00;
    bus.chan_mask_i = 8'h00;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask_enable();
    test_reset_in_offer();
`ifdef MUX8_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux8_rr_scheduler

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
Round-robin scheduler that shares the 8-input registered byte multiplexer between eight requesting channels (per-bus receive buffers in the hub). It drives the mux select and enable and waits out the mux's one-cycle register latency. It then offers the selected byte downstream on a valid/ready handshake and acknowledges the served channel. One transfer is in flight at a time.

Parameters:
SEL_W, 8, width of sel_o; must match the mux select width; upper SEL_W-3 bits always driven 0.
PTR_RST, 0, round-robin pointer value after reset (0..7).
TIMEOUT_CYCLES, 255, OFFER-state watchdog limit; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
enable_i  in  1  1 = new grants allowed; 0 = finish in-flight transfer only.
req_i  in  8  per-channel request, level; held until acknowledged.
chan_mask_i  in  8  1 = channel eligible; sampled only in IDLE.
sel_o  out  SEL_W  mux select; binary channel index.
en_sel_o  out  1  mux load enable; one-cycle pulse.
out_valid_o  out  1  mux data_out holds a valid byte for downstream.
out_ready_i  in  1  downstream accepts byte when out_valid_o & out_ready_i.
chan_o  out  3  index of the channel being offered (= sel_o[2:0]).
req_ack_o  out  8  one-hot, one-cycle pulse to the served channel.
busy_o  out  1  1 when state != IDLE.
timeout_err_o  out  1  one-cycle watchdog pulse; present only with the optional feature.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, ptr=PTR_RST, sel_o=0, en_sel_o=0, out_valid_o=0, req_ack_o=0, timeout_err_o=0, watchdog counter=0. Reset overrides every state; a transfer is abandoned without req_ack.
- States:
  - IDLE: eligible = req_i & chan_mask_i. If enable_i and eligible != 0, winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8). Register sel_o=winner, go to SELECT. Otherwise stay in IDLE with all strobes 0.
  - SELECT: en_sel_o=1 for exactly this cycle, with sel_o stable; the mux loads at the end of this cycle. Next state is OFFER.
  - OFFER: out_valid_o=1 and en_sel_o=0, so the mux holds its output. On out_ready_i=1, the handshake completes in this cycle and the next state is RELEASE. Otherwise stay in OFFER with sel_o unchanged.
  - RELEASE: out_valid_o=0, req_ack_o = one-hot(sel_o) for this cycle, ptr = (sel_o+1) mod 8. Next state is IDLE.
- Throughput: minimum 4 cycles per transfer (IDLE, SELECT, OFFER, RELEASE); first grant appears 1 cycle after req_i is seen.
- Requester contract: drop req_i on the edge that ends its req_ack_o pulse. Re-requests are served only after the other pending channels.
- Outputs are registered from state; sel_o changes only on the IDLE->SELECT transition.
- enable_i=0 or chan_mask_i changes during SELECT/OFFER/RELEASE do not affect the current transfer.
- req_i deasserting after grant is ignored: the transfer completes and the ack is still issued.
- Pointer wrap: serving channel 7 sets ptr=0.
- Simultaneous requests: only the round-robin winner is granted; the others wait, and their req_i stays high.

Optional Feature:
MUX8_SCHED_TIMEOUT_EN
- Defined: a counter runs while in OFFER and clears on entry to OFFER. If out_ready_i stays 0 for TIMEOUT_CYCLES consecutive OFFER cycles:
  - drop out_valid_o and pulse timeout_err_o for 1 cycle;
  - send no req_ack_o;
  - set ptr=(sel_o+1) mod 8 so the stalled channel loses priority;
  - go to IDLE.
- Undefined: no counter and no timeout_err_o port; OFFER waits indefinitely.

Test Plan:
1. Reset, enable_i=1, mask=FF, req_i=0x08, out_ready_i=1 -> sel_o=3, en_sel_o pulse next cycle, out_valid_o next, req_ack_o=0x08 next, ptr=4; total 4 cycles.
2. req_i=0xFF held, ptr=0, ready=1, dropping each req on ack -> service order 0,1,...,7, one transfer per 4 cycles, chan_o matches each req_ack_o bit.
3. Backpressure: single req ch5, out_ready_i=0 for 6 OFFER cycles then 1 -> out_valid_o high 7 cycles, sel_o stays 5, exactly one ack 0x20.
4. mask=0x0F, req_i=0xF0 -> no grant, busy_o=0. Then mask=0xFF -> grant ch4.
5. rst=0 during OFFER -> next cycle all outputs 0, state IDLE, ptr=PTR_RST, no req_ack_o.
6. With MUX8_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready=0 -> out_valid_o for 4 cycles, timeout_err_o pulse, no ack, next grant goes to the next pending channel.
